muldiv_ctrl: RTL and testbench
==============================

MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have parameter: MUL_LAT, 2, multiplier pipeline depth in cycles (legal 1..15).
REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- op_valid  in  1  EX presents a mul/div op, held until stallreq drops.
- op_type  in  2  00 mul (signed), 01 mulu, 10 div (signed), 11 divu.
- op_a, op_b  in  32  source operands (rs, rt).
- flush  in  1  cancel any in-flight op.
- stallreq  out  1  pipeline stall request.
- res_valid  out  1  one-cycle pulse; result valid.
- res_hi, res_lo  out  32  captured hi/lo result.
- mul_signed  out  1  multiplier signedness.
- mul_ina, mul_inb  out  32  multiplier operands.
- mul_result  in  64  multiplier product.
- div_start  out  1  divider start, level.
- div_annul  out  1  divider abort pulse.
- div_signed  out  1  divider signedness.
- div_opa, div_opb  out  32  dividend, divisor.
- div_ready  in  1  divider result valid.
- div_result  in  64  {remainder, quotient}.

Function
REQ-003 SHALL implement FSM states IDLE, MUL, DIV, DONE.
REQ-004 IDLE: op_valid=1, flush=0 -> latch op_a/op_b/op_type into operand registers; go to MUL (op_type[1]=0) or DIV (op_type[1]=1).
REQ-005 Operand registers SHALL drive mul_ina/mul_inb, div_opa/div_opb; mul_signed/div_signed SHALL be ~latched op_type[0].
REQ-006 MUL: 4-bit counter loaded 0 on entry, increments each cycle; at count==MUL_LAT-1 capture mul_result[63:32]->res_hi, [31:0]->res_lo, go to DONE.
REQ-007 DIV: div_start=1 every cycle in DIV; on div_ready=1 capture div_result[63:32]->res_hi, [31:0]->res_lo, drop div_start next cycle, go to DONE.
REQ-008 DONE: res_valid=1 exactly one cycle, stallreq=0, then IDLE; op_valid seen in DONE SHALL NOT start a new op.
REQ-009 stallreq SHALL be combinational: (IDLE & op_valid & ~flush) | MUL | DIV.
REQ-010 Mul latency: op accepted cycle T -> res_valid at T+MUL_LAT+1; stallreq high T..T+MUL_LAT.
REQ-011 flush=1 in MUL or DIV -> IDLE next cycle, no res_valid, res_hi/res_lo unchanged.
REQ-012 flush=1 in DIV -> div_annul=1 for that one cycle, div_start=0 same cycle.
REQ-013 flush with div_ready in same cycle: flush wins, result discarded.
REQ-014 flush with op_valid in IDLE: nothing latched, stallreq=0.
REQ-015 res_hi/res_lo SHALL hold their last value until the next capture.

Reset
REQ-016 resetn=0 SHALL immediately force IDLE, counter 0, operand registers 0.
REQ-017 Reset values SHALL be 0 for stallreq, res_valid, res_hi, res_lo, div_start, div_annul, div_signed, div_opa, div_opb, mul_signed, mul_ina, mul_inb.
REQ-018 Reset mid-MUL/DIV SHALL abandon the op without res_valid; div_annul is not pulsed.

Configuration
REQ-019 Macro DIVZERO_FAST_EN defined: div op with op_b==0 in IDLE goes directly to DONE (div_start never asserted), res_hi=op_a, res_lo=32'hFFFFFFFF, res_valid at T+1.
REQ-020 Macro DIVZERO_FAST_EN undefined: divide-by-zero follows normal DIV path; result is whatever div_result returns.

Verification
REQ-021 op_type=00, op_a=32'hFFFFFFFE, op_b=3, MUL_LAT=2 -> res_hi=32'hFFFFFFFF, res_lo=32'hFFFFFFFA, res_valid at T+3, stallreq high T..T+2.
REQ-022 op_type=11, op_a=100, op_b=7, div_ready after 33 cycles -> div_start high until ready, res_hi=2, res_lo=14, single res_valid pulse.
REQ-023 op_type=10 in DIV, flush at cycle 5 -> div_annul one pulse, IDLE next cycle, res_valid stays 0, res_hi/res_lo unchanged.
REQ-024 op_type=10, op_a=9, op_b=0 with DIVZERO_FAST_EN -> res_hi=9, res_lo=32'hFFFFFFFF at T+1, div_start never 1.
REQ-025 resetn dropped mid-MUL asynchronously -> all outputs 0 before next clk edge; new op after release completes normally.

Source files
------------

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequences one multiply or divide at a time for the EX stage.
// Multiplies wait MUL_LAT cycles on an external multiplier; divides hold
// div_start until the external divider raises div_ready. flush abandons the
// in-flight op (and pulses div_annul for a divide).
// Optional feature macro: DIVZERO_FAST_EN. When defined, a divide by zero
// skips the divider and returns {hi, lo} = {op_a, 32'hFFFFFFFF} one cycle
// after acceptance.
// Handshake: EX holds op_valid and the operands steady while stallreq is
// high; an op is taken in the IDLE cycle where op_valid=1 and flush=0, and
// its result appears as a single res_valid pulse in the DONE cycle, where
// stallreq is low and op_valid is ignored.
module muldiv_ctrl #(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_valid,
  input  logic [1:0]  op_type,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        flush,
  output logic        stallreq,
  output logic        res_valid,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        mul_signed,
  output logic [31:0] mul_ina,
  output logic [31:0] mul_inb,
  input  logic [63:0] mul_result,
  output logic        div_start,
  output logic        div_annul,
  output logic        div_signed,
  output logic [31:0] div_opa,
  output logic [31:0] div_opb,
  input  logic        div_ready,
  input  logic [63:0] div_result,
  output logic [1:0]  fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [3:0] MUL_LAST = 4'(MUL_LAT - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q;
  logic [31:0] opa_q, opb_q;
  logic        sgn_q;
  logic [31:0] hi_q, lo_q;
  logic        accept, cap_mul, cap_div, fast_zero;

  // Signedness is kept as its own register (not the raw op_type bit) so
  // that it reads 0 out of reset.
  assign mul_ina    = opa_q;
  assign mul_inb    = opb_q;
  assign div_opa    = opa_q;
  assign div_opb    = opb_q;
  assign mul_signed = sgn_q;
  assign div_signed = sgn_q;
  assign res_hi     = hi_q;
  assign res_lo     = lo_q;
  assign fsm_state  = state_q;

  // State register; reset abandons any op without a result pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state and handshake outputs; flush has priority over completion.
  always_comb begin
    state_d   = state_q;
    stallreq  = 1'b0;
    res_valid = 1'b0;
    div_start = 1'b0;
    div_annul = 1'b0;
    accept    = 1'b0;
    cap_mul   = 1'b0;
    cap_div   = 1'b0;
    fast_zero = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (op_valid && !flush) begin
          stallreq = 1'b1;
          accept   = 1'b1;
          if (op_type[1]) state_d = S_DIV;
          else            state_d = S_MUL;
`ifdef DIVZERO_FAST_EN
          if (op_type[1] && (op_b == 32'd0)) begin
            state_d   = S_DONE;
            fast_zero = 1'b1;
          end
`endif
        end
      end
      S_MUL: begin
        stallreq = 1'b1;
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == MUL_LAST) begin
          cap_mul = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        stallreq = 1'b1;
        if (flush) begin
          div_annul = 1'b1;
          state_d   = S_IDLE;
        end else begin
          div_start = 1'b1;
          if (div_ready) begin
            cap_div = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        res_valid = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture on acceptance and multiplier cycle counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      opa_q <= 32'd0;
      opb_q <= 32'd0;
      sgn_q <= 1'b0;
      cnt_q <= 4'd0;
    end else if (accept) begin
      opa_q <= op_a;
      opb_q <= op_b;
      sgn_q <= ~op_type[0];
      cnt_q <= 4'd0;
    end else if (state_q == S_MUL) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

  // Result registers hold their value until the next completed op.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else if (fast_zero) begin
      hi_q <= op_a;
      lo_q <= 32'hFFFF_FFFF;
    end else if (cap_mul) begin
      hi_q <= mul_result[63:32];
      lo_q <= mul_result[31:0];
    end else if (cap_div) begin
      hi_q <= div_result[63:32];
      lo_q <= div_result[31:0];
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: directed bench for muldiv_ctrl with a behavioural
// multiplier/divider environment and a cycle-level reference model.
module tb_muldiv_ctrl;

  localparam int MUL_LAT = 2;

  logic        clk, resetn;
  logic        op_valid, flush;
  logic [1:0]  op_type;
  logic [31:0] op_a, op_b;
  logic        stallreq, res_valid;
  logic [31:0] res_hi, res_lo;
  logic        mul_signed;
  logic [31:0] mul_ina, mul_inb;
  logic [63:0] mul_result;
  logic        div_start, div_annul, div_signed;
  logic [31:0] div_opa, div_opb;
  logic        div_ready;
  logic [63:0] div_result;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int ds_cycles = 0;
  int div_lat  = 5;
  int dcnt     = 0;

  muldiv_ctrl #(.MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .resetn(resetn), .op_valid(op_valid), .op_type(op_type),
    .op_a(op_a), .op_b(op_b), .flush(flush), .stallreq(stallreq),
    .res_valid(res_valid), .res_hi(res_hi), .res_lo(res_lo),
    .mul_signed(mul_signed), .mul_ina(mul_ina), .mul_inb(mul_inb),
    .mul_result(mul_result), .div_start(div_start), .div_annul(div_annul),
    .div_signed(div_signed), .div_opa(div_opa), .div_opb(div_opb),
    .div_ready(div_ready), .div_result(div_result), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (div_start) ds_cycles <= ds_cycles + 1;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // arithmetic references
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    logic [63:0] p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    if (s) p = sa * sb;
    else   p = {32'd0, a} * {32'd0, b};
    return p;
  endfunction

  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [31:0] q, r;
    if (b == 32'd0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  // environment: combinational multiplier, iterative divider of div_lat cycles
  assign mul_result = ref_mul(mul_ina, mul_inb, mul_signed);

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      div_ready  <= 1'b0;
      dcnt       <= 0;
      div_result <= 64'd0;
    end else begin
      dcnt       <= div_start ? dcnt + 1 : 0;
      div_ready  <= div_start && (dcnt == div_lat - 1);
      div_result <= ref_div(div_opa, div_opb, div_signed);
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // scoreboard / reference model
  logic [63:0] exp_q[$];
  int          m_pend = 0;   // 0 none, 1 multiply, 2 divide
  int          m_age  = 0;
  bit          m_done = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_a = 0, m_b = 0;
  logic        m_sgn = 0;

  always @(negedge clk) begin
    logic        exp_stall;
    logic [63:0] tmp;
    if (!resetn) begin
      exp_q.delete();
      m_pend = 0; m_age = 0; m_done = 0;
      m_hi = 0; m_lo = 0; m_a = 0; m_b = 0; m_sgn = 0;
      check("rst_stallreq", 64'(stallreq), 64'd0);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_res", {res_hi, res_lo}, 64'd0);
      check("rst_div_start", 64'(div_start), 64'd0);
      check("rst_div_annul", 64'(div_annul), 64'd0);
      check("rst_operands", {mul_ina, mul_inb}, 64'd0);
      check("rst_div_ops", {div_opa, div_opb}, 64'd0);
      check("rst_signed", {62'd0, mul_signed, div_signed}, 64'd0);
    end else begin
      exp_stall = (m_pend != 0) || (!m_done && m_pend == 0 && op_valid && !flush);
      check("stallreq", 64'(stallreq), 64'(exp_stall));
      check("res_valid", 64'(res_valid), 64'(m_done));
      check("res_hi", 64'(res_hi), 64'(m_hi));
      check("res_lo", 64'(res_lo), 64'(m_lo));
      check("div_start", 64'(div_start), 64'(m_pend == 2 && !flush));
      check("div_annul", 64'(div_annul), 64'(m_pend == 2 && flush));
      check("mul_ops", {mul_ina, mul_inb}, {m_a, m_b});
      check("div_ops", {div_opa, div_opb}, {m_a, m_b});
      check("signed", {62'd0, mul_signed, div_signed}, {62'd0, m_sgn, m_sgn});
      if (m_done) begin
        m_done = 0;
      end else if (m_pend == 0) begin
        if (op_valid && !flush) begin
          m_a = op_a; m_b = op_b; m_sgn = ~op_type[0];
          if (op_type[1]) exp_q.push_back(ref_div(op_a, op_b, ~op_type[0]));
          else            exp_q.push_back(ref_mul(op_a, op_b, ~op_type[0]));
          m_pend = op_type[1] ? 2 : 1;
          m_age  = 0;
`ifdef DIVZERO_FAST_EN
          if (op_type[1] && op_b == 32'd0) begin
            tmp = exp_q.pop_front();
            m_pend = 0; m_hi = op_a; m_lo = 32'hFFFF_FFFF; m_done = 1;
          end
`endif
        end
      end else if (flush) begin
        m_pend = 0;
        tmp = exp_q.pop_front();
      end else if (m_pend == 1) begin
        m_age++;
        if (m_age == MUL_LAT) begin
          tmp = exp_q.pop_front();
          {m_hi, m_lo} = tmp;
          m_pend = 0; m_done = 1;
        end
      end else if (div_ready) begin
        tmp = exp_q.pop_front();
        {m_hi, m_lo} = tmp;
        m_pend = 0; m_done = 1;
      end
    end
  end

  // driver: present an op, hold it while stalled, check completion cycle
  task automatic do_op(input logic [1:0] t, input logic [31:0] a, input logic [31:0] b,
                       input int exp_lat, output logic [31:0] hi, output logic [31:0] lo);
    int t_acc;
    bit seen;
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = t; op_a = a; op_b = b;
    t_acc = cyc; seen = 0;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!stallreq) begin seen = 1; break; end
      @(posedge clk); #1;
    end
    check("op_completed", 64'(seen), 64'd1);
    check("res_valid_at_done", 64'(res_valid), 64'd1);
    check("latency", 64'(cyc - t_acc), 64'(exp_lat));
    hi = res_hi; lo = res_lo;
    @(posedge clk); #1;
    op_valid = 1'b0;
  endtask

  logic [31:0] hi, lo;
  int ds_base;

  initial begin
    resetn = 1'b0; op_valid = 1'b0; flush = 1'b0;
    op_type = 2'b00; op_a = 32'd0; op_b = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("init_res", {res_hi, res_lo}, 64'd0);
    check("init_stall_valid", {62'd0, stallreq, res_valid}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // signed multiply -2 * 3
    do_op(2'b00, 32'hFFFF_FFFE, 32'd3, MUL_LAT + 1, hi, lo);
    check("mul_s_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mul_s_lo", 64'(lo), 64'hFFFF_FFFA);

    // unsigned multiply
    do_op(2'b01, 32'hFFFF_FFFE, 32'd3, MUL_LAT + 1, hi, lo);
    check("mul_u_hi", 64'(hi), 64'd2);
    check("mul_u_lo", 64'(lo), 64'hFFFF_FFFA);

    // unsigned divide 100 / 7 with a long divider
    div_lat = 33;
    ds_base = ds_cycles;
    do_op(2'b11, 32'd100, 32'd7, 35, hi, lo);
    check("divu_hi", 64'(hi), 64'd2);
    check("divu_lo", 64'(lo), 64'd14);
    check("divu_start_cycles", 64'(ds_cycles - ds_base), 64'd34);

    // signed divide -100 / 7
    div_lat = 4;
    do_op(2'b10, 32'hFFFF_FF9C, 32'd7, 6, hi, lo);
    check("div_s_hi", 64'(hi), 64'hFFFF_FFFE);
    check("div_s_lo", 64'(lo), 64'hFFFF_FFF2);

    // flush a signed divide five cycles after acceptance
    div_lat = 33;
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 2'b10; op_a = 32'd50; op_b = 32'd3;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("fdiv_annul", 64'(div_annul), 64'd1);
    check("fdiv_start_low", 64'(div_start), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fdiv_idle", {62'd0, stallreq, res_valid}, 64'd0);
    check("fdiv_annul_once", 64'(div_annul), 64'd0);
    check("fdiv_res_held", {res_hi, res_lo}, 64'hFFFF_FFFE_FFFF_FFF2);
    repeat (3) @(posedge clk);

    // flush a multiply in its first cycle
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 2'b01; op_a = 32'd5; op_b = 32'd5;
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b1;
    @(negedge clk);
    check("fmul_no_annul", 64'(div_annul), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("fmul_idle", {62'd0, stallreq, res_valid}, 64'd0);
    check("fmul_res_held", {res_hi, res_lo}, 64'hFFFF_FFFE_FFFF_FFF2);
    repeat (3) @(posedge clk);

    // flush in the same cycle the divider reports ready
    div_lat = 3;
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 2'b11; op_a = 32'd20; op_b = 32'd6;
    @(posedge clk); #1;
    op_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("frdy_ready_seen", 64'(div_ready), 64'd1);
    check("frdy_annul", 64'(div_annul), 64'd1);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("frdy_no_valid", 64'(res_valid), 64'd0);
    check("frdy_res_held", {res_hi, res_lo}, 64'hFFFF_FFFE_FFFF_FFF2);
    repeat (3) @(posedge clk);

    // flush together with op_valid in IDLE: nothing taken
    @(posedge clk); #1;
    op_valid = 1'b1; flush = 1'b1; op_type = 2'b00; op_a = 32'd123; op_b = 32'd456;
    @(negedge clk);
    check("fidle_stall", 64'(stallreq), 64'd0);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("fidle_stall_after", 64'(stallreq), 64'd0);
    check("fidle_ops_kept", {mul_ina, div_opb}, {32'd20, 32'd6});

    // divide by zero
    div_lat = 4;
    ds_base = ds_cycles;
`ifdef DIVZERO_FAST_EN
    do_op(2'b10, 32'd9, 32'd0, 1, hi, lo);
    check("dz_start_cycles", 64'(ds_cycles - ds_base), 64'd0);
`else
    do_op(2'b10, 32'd9, 32'd0, 6, hi, lo);
    check("dz_start_cycles", 64'(ds_cycles - ds_base), 64'd5);
`endif
    check("dz_hi", 64'(hi), 64'd9);
    check("dz_lo", 64'(lo), 64'hFFFF_FFFF);

    // asynchronous reset in the middle of a multiply
    @(posedge clk); #1;
    op_valid = 1'b1; op_type = 2'b00; op_a = 32'd7; op_b = 32'd9;
    @(posedge clk); #2;
    resetn = 1'b0; op_valid = 1'b0;
    #1;
    check("arst_stall_valid", {62'd0, stallreq, res_valid}, 64'd0);
    check("arst_res", {res_hi, res_lo}, 64'd0);
    check("arst_ops", {mul_ina, mul_inb}, 64'd0);
    check("arst_div", {61'd0, div_start, div_annul, mul_signed}, 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    do_op(2'b00, 32'd7, 32'd6, MUL_LAT + 1, hi, lo);
    check("post_rst_mul", {hi, lo}, 64'd42);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
